// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: walks each instruction through fetch/decode/execute/memory/writeback,
// stalls on the unified memory via mem_ready, and counts retired instructions.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4; load IR and PC on mem_ready
// DECODE | compute branch target, dispatch on op/func
// MEMADR | ALUOut = A + sign-ext imm (lw/sw address)
// MEMRD  | read data memory at ALUOut
// MEMWB  | write MDR to rt
// MEMWR  | write B to memory at ALUOut
// EXEC   | R-type ALU operation on A, B
// RWB    | write ALUOut to rd
// BRANCH | compare A, B; take branch on zero
// JUMP   | load PC with jump target
// IEXEC  | addi: A + sign-ext imm
// IWB    | write ALUOut to rt
module multicycle_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrc_a,
    output logic [1:0]  alusrc_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state, nxt_state;
    logic   retire;

    logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c;
    logic       regdst_c, memtoreg_c, regwrite_c, alusrc_a_c, illegal_c;
    logic [1:0] alusrc_b_c, pc_src_c;
    logic [2:0] alu_ctrl_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
            retired   <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire)
                retired <= retired + 32'd1;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        retire      = 1'b0;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        iord_c      = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        regdst_c    = 1'b0;
        memtoreg_c  = 1'b0;
        regwrite_c  = 1'b0;
        alusrc_a_c  = 1'b0;
        alusrc_b_c  = 2'b00;
        alu_ctrl_c  = ALU_AND;
        pc_src_c    = 2'b00;
        illegal_c   = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_read_c = 1'b1;
                alusrc_b_c = 2'b01;
                alu_ctrl_c = ALU_ADD;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    nxt_state  = DECODE;
                end
            end
            DECODE: begin
                alusrc_b_c = 2'b11;
                alu_ctrl_c = ALU_ADD;
                nxt_state  = FETCH;
                case (op)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
                    OP_ADDI:      nxt_state = IEXEC;
                    OP_RTYPE: begin
                        case (func)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt_state = EXEC;
                            FN_NOP:  retire    = 1'b1;
                            default: illegal_c = 1'b1;
                        endcase
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrc_a_c = 1'b1;
                alusrc_b_c = 2'b10;
                alu_ctrl_c = ALU_ADD;
                nxt_state  = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (mem_ready)
                    nxt_state = MEMWB;
            end
            MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                nxt_state  = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (mem_ready) begin
                    nxt_state = FETCH;
                    retire    = 1'b1;
                end
            end
            EXEC: begin
                alusrc_a_c = 1'b1;
                nxt_state  = RWB;
                case (func)
                    FN_SUB:  alu_ctrl_c = ALU_SUB;
                    FN_AND:  alu_ctrl_c = ALU_AND;
                    FN_OR:   alu_ctrl_c = ALU_OR;
                    FN_SLT:  alu_ctrl_c = ALU_SLT;
                    default: alu_ctrl_c = ALU_ADD;
                endcase
            end
            RWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                nxt_state  = FETCH;
                retire     = 1'b1;
            end
            BRANCH: begin
                alusrc_a_c = 1'b1;
                alu_ctrl_c = ALU_SUB;
                pc_src_c   = 2'b01;
                pc_write_c = zero;
                nxt_state  = FETCH;
                retire     = 1'b1;
            end
            JUMP: begin
                pc_src_c   = 2'b10;
                pc_write_c = 1'b1;
                nxt_state  = FETCH;
                retire     = 1'b1;
            end
            IEXEC: begin
                alusrc_a_c = 1'b1;
                alusrc_b_c = 2'b10;
                alu_ctrl_c = ALU_ADD;
                nxt_state  = IWB;
            end
            IWB: begin
                regwrite_c = 1'b1;
                nxt_state  = FETCH;
                retire     = 1'b1;
            end
            default: nxt_state = FETCH;
        endcase
    end

    // Reset blanks every strobe asynchronously, even though FETCH would otherwise request memory.
    assign pc_write  = pc_write_c  & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign iord      = iord_c      & ~reset;
    assign mem_read  = mem_read_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign regdst    = regdst_c    & ~reset;
    assign memtoreg  = memtoreg_c  & ~reset;
    assign regwrite  = regwrite_c  & ~reset;
    assign alusrc_a  = alusrc_a_c  & ~reset;
    assign alusrc_b  = reset ? 2'b00 : alusrc_b_c;
    assign alu_ctrl  = reset ? 3'b000 : alu_ctrl_c;
    assign pc_src    = reset ? 2'b00 : pc_src_c;
    assign illegal   = illegal_c   & ~reset;
    assign state     = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction state trajectories and control
// vectors are built from instruction class and wait counts, then compared cycle by cycle.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  op, func;
    logic        zero, mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        regdst, memtoreg, regwrite, alusrc_a, illegal;
    logic [1:0]  alusrc_b, pc_src;
    logic [2:0]  alu_ctrl;
    logic [3:0]  state;
    logic [31:0] retired;
    logic [16:0] ctrl;

    int checks = 0;
    int errors = 0;
    int exp_retired = 0;

    localparam int K_LW = 0, K_SW = 1, K_BEQ = 2, K_J = 3, K_ADDI = 4;
    localparam int K_R = 5, K_NOP = 6, K_ILL = 7;

    always #5 clock = ~clock;

    multicycle_controller dut (
        .clock(clock), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .illegal(illegal), .state(state), .retired(retired)
    );

    assign ctrl = {pc_write, ir_write, iord, mem_read, mem_write, regdst, memtoreg, regwrite,
                   alusrc_a, alusrc_b, alu_ctrl, pc_src, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b001000: return K_ADDI;
            6'b000000: begin
                if (f == 6'b000000) return K_NOP;
                if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return K_R;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    // Expected control vector for one cycle, straight from the per-state output list.
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                             input logic [5:0] f, input logic ill);
        logic pcw, irw, ad, mr, mw, rd, m2r, rw, a, il;
        logic [1:0] b, ps;
        logic [2:0] alu;
        {pcw, irw, ad, mr, mw, rd, m2r, rw, a, il} = '0;
        b = 2'b00; ps = 2'b00; alu = 3'b000;
        case (st)
            0:  begin mr = 1; b = 2'b01; alu = 3'b010; pcw = rdy; irw = rdy; end
            1:  begin b = 2'b11; alu = 3'b010; il = ill; end
            2:  begin a = 1; b = 2'b10; alu = 3'b010; end
            3:  begin mr = 1; ad = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; ad = 1; end
            6:  begin
                a = 1;
                alu = (f == 6'b100010) ? 3'b110 : (f == 6'b100100) ? 3'b000 :
                      (f == 6'b100101) ? 3'b001 : (f == 6'b101010) ? 3'b111 : 3'b010;
            end
            7:  begin rw = 1; rd = 1; end
            8:  begin a = 1; alu = 3'b110; ps = 2'b01; pcw = z; end
            9:  begin ps = 2'b10; pcw = 1; end
            10: begin a = 1; b = 2'b10; alu = 3'b010; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, irw, ad, mr, mw, rd, m2r, rw, a, b, alu, ps, il};
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wm);
        int  k;
        int  sq[$];
        logic rq[$];
        k = classify(o, f);
        op = o; func = f; zero = z;
        for (int i = 0; i < wf; i++) begin sq.push_back(0); rq.push_back(1'b0); end
        sq.push_back(0); rq.push_back(1'b1);
        sq.push_back(1); rq.push_back(1'($urandom));
        case (k)
            K_LW, K_SW: begin
                sq.push_back(2); rq.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin
                    sq.push_back(k == K_LW ? 3 : 5); rq.push_back(1'b0);
                end
                sq.push_back(k == K_LW ? 3 : 5); rq.push_back(1'b1);
                if (k == K_LW) begin sq.push_back(4); rq.push_back(1'($urandom)); end
            end
            K_BEQ:  begin sq.push_back(8); rq.push_back(1'($urandom)); end
            K_J:    begin sq.push_back(9); rq.push_back(1'($urandom)); end
            K_ADDI: begin
                sq.push_back(10); rq.push_back(1'($urandom));
                sq.push_back(11); rq.push_back(1'($urandom));
            end
            K_R: begin
                sq.push_back(6); rq.push_back(1'($urandom));
                sq.push_back(7); rq.push_back(1'($urandom));
            end
            default: ;
        endcase
        for (int i = 0; i < sq.size(); i++) begin
            #1 mem_ready = rq[i];
            #1;
            check($sformatf("state op=%b f=%b cyc%0d", o, f, i), 32'(state), 32'(sq[i]));
            check($sformatf("ctrl st=%0d op=%b f=%b", sq[i], o, f), 32'(ctrl),
                  32'(exp_ctrl(sq[i], rq[i], z, f, k == K_ILL)));
            @(posedge clock);
        end
        if (k != K_ILL) exp_retired++;
        #1 check($sformatf("retired op=%b f=%b", o, f), retired, 32'(exp_retired));
    endtask

    task automatic run_random();
        int kind;
        logic [5:0] o, f;
        logic [5:0] rfn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        kind = $urandom_range(0, 7);
        f = 6'($urandom);
        case (kind)
            K_LW:   o = 6'b100011;
            K_SW:   o = 6'b101011;
            K_BEQ:  o = 6'b000100;
            K_J:    o = 6'b000010;
            K_ADDI: o = 6'b001000;
            K_R:    begin o = 6'b000000; f = rfn[$urandom_range(0, 4)]; end
            K_NOP:  begin o = 6'b000000; f = 6'b000000; end
            default: begin
                o = 6'($urandom);
                for (int n = 0; n < 100 && classify(o, f) != K_ILL; n++) begin
                    o = 6'($urandom); f = 6'($urandom);
                end
                if (classify(o, f) != K_ILL) o = 6'b111111;
            end
        endcase
        run_instr(o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; op = '0; func = '0; zero = 1'b0;
        #12;
        check("reset ctrl", 32'(ctrl), 32'd0);
        check("reset state", 32'(state), 32'd0);
        check("reset retired", retired, 32'd0);
        @(negedge clock);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1 check("first fetch mem_read", 32'(mem_read), 32'd1);
        @(posedge clock);

        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
        run_instr(6'b000000, 6'b100100, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 1, 1);
        run_instr(6'b000010, 6'b000000, 1'b0, 2, 0);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b100101, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);

        for (int i = 0; i < 120; i++) run_random();

        // sw stalled in MEMWR, then reset mid-wait
        op = 6'b101011; func = '0; zero = 1'b0;
        #1 mem_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1 mem_ready = 1'b0;
        #1 check("memwr wait state", 32'(state), 32'd5);
        check("memwr wait mem_write", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("mid reset mem_write", 32'(mem_write), 32'd0);
        check("mid reset ctrl", 32'(ctrl), 32'd0);
        check("mid reset state", 32'(state), 32'd0);
        check("mid reset retired", retired, 32'd0);
        exp_retired = 0;
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
